// File: rtl/core_pkg.sv
// Shared types and constants for the RV32I core run controller.
package core_pkg;

    localparam int XLEN_DEF = 32;
    localparam int REG_ZERO = 0;
    localparam int REG_A0   = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_RUN,
        ST_HALTED,
        ST_TIMEOUT
    } run_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en && (q != '1))
            q <= q + W'(1);
    end

endmodule

// File: rtl/core_run_ctrl.sv
// Run controller for core_sc: reset sequencing, cycle/retire counting,
// PC self-loop halt detection, cycle timeout and result capture.
module core_run_ctrl
    import core_pkg::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int CNT_W       = 32,
    parameter int RST_CYCLES  = 3,
    parameter int MAX_CYCLES  = 50,
    parameter int HALT_REPEAT = 2,
    parameter int RESULT_REG  = REG_A0,
    parameter int PASS_VALUE  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [XLEN-1:0]  pc,
    input  logic             retire,
    input  logic             rd_we,
    input  logic [4:0]       rd_addr,
    input  logic [XLEN-1:0]  rd_data,
    output logic             core_rst,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic             pass,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [XLEN-1:0]  halt_pc,
    output logic [XLEN-1:0]  result
);

    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int RPW = $clog2(HALT_REPEAT + 1);

    localparam logic [RCW-1:0]   RST_LOAD = RCW'(RST_CYCLES - 1);
    localparam logic [RPW-1:0]   HALT_R   = RPW'(HALT_REPEAT);
    localparam logic [CNT_W-1:0] MAX_M1   = CNT_W'(MAX_CYCLES - 1);
    localparam logic [XLEN-1:0]  PASS_V   = XLEN'(PASS_VALUE);
    localparam logic [4:0]       RES_IDX  = 5'(RESULT_REG);
    localparam logic [4:0]       ZERO_IDX = 5'(REG_ZERO);

    run_state_t      state, state_nx;
    logic [RCW-1:0]  rst_cnt, rst_cnt_nx;
    logic [RPW-1:0]  repeat_cnt, rep_nx;
    logic [XLEN-1:0] prev_pc, result_nx;
    logic            in_run, launch, same_pc, halt_hit, tmo_hit, wr_hit;

    // A zero repeat_cnt means no PC has retired yet, so prev_pc is not valid.
    assign in_run    = (state == ST_RUN);
    assign launch    = start && ((state == ST_IDLE) || (state == ST_HALTED) || (state == ST_TIMEOUT));
    assign same_pc   = (repeat_cnt != '0) && (pc == prev_pc);
    assign rep_nx    = same_pc ? (repeat_cnt + RPW'(1)) : RPW'(1);
    assign halt_hit  = in_run && retire && (rep_nx >= HALT_R);
    assign tmo_hit   = in_run && (cycle_cnt == MAX_M1);
    assign wr_hit    = in_run && rd_we && (rd_addr == RES_IDX) && (rd_addr != ZERO_IDX);
    assign result_nx = wr_hit ? rd_data : result;

    // core_rst follows rst asynchronously so the core is held the instant rst rises.
    assign core_rst = rst | (state != ST_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            rst_cnt <= '0;
        end else begin
            state   <= state_nx;
            rst_cnt <= rst_cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        rst_cnt_nx = rst_cnt;
        case (state)
            ST_IDLE, ST_HALTED, ST_TIMEOUT: begin
                if (start) begin
                    state_nx   = ST_RESET;
                    rst_cnt_nx = RST_LOAD;
                end
            end
            ST_RESET: begin
                if (rst_cnt == '0)
                    state_nx = ST_RUN;
                else
                    rst_cnt_nx = rst_cnt - RCW'(1);
            end
            ST_RUN: begin
                if (halt_hit)
                    state_nx = ST_HALTED;
                else if (tmo_hit)
                    state_nx = ST_TIMEOUT;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running    <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            pass       <= 1'b0;
            prev_pc    <= '0;
            repeat_cnt <= '0;
            result     <= '0;
            halt_pc    <= '0;
        end else begin
            running <= (state_nx == ST_RUN);
            done    <= (state_nx == ST_HALTED);
            timeout <= (state_nx == ST_TIMEOUT);
            if (launch) begin
                pass       <= 1'b0;
                prev_pc    <= '0;
                repeat_cnt <= '0;
                result     <= '0;
                halt_pc    <= '0;
            end else if (in_run) begin
                result <= result_nx;
                if (retire) begin
                    repeat_cnt <= rep_nx;
                    prev_pc    <= pc;
                end
                // The halting cycle's own writeback counts toward pass.
                if (halt_hit) begin
                    halt_pc <= pc;
                    pass    <= (result_nx == PASS_V);
                end
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (launch),
        .en  (in_run),
        .q   (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_retire_cnt (
        .clk (clk),
        .rst (rst),
        .clr (launch),
        .en  (in_run && retire),
        .q   (retire_cnt)
    );

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl: vector table for a full run plus
// hand sequences for fail result, timeout, halt/timeout collision and mid-run reset.
module tb_core_run_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, retire, rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] pc, rd_data;

    logic        core_rst, running, done, timeout, pass;
    logic [31:0] cycle_cnt, retire_cnt, halt_pc, result;

    logic        z_core_rst, z_running, z_done, z_timeout, z_pass;
    logic [31:0] z_cycle_cnt, z_retire_cnt, z_halt_pc, z_result;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    core_run_ctrl u_dut (
        .clk(clk), .rst(rst), .start(start), .pc(pc), .retire(retire),
        .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
        .core_rst(core_rst), .running(running), .done(done), .timeout(timeout),
        .pass(pass), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt),
        .halt_pc(halt_pc), .result(result)
    );

    // Result register pointed at x0: nothing may ever be captured.
    core_run_ctrl #(.RESULT_REG(0)) u_dut_x0 (
        .clk(clk), .rst(rst), .start(start), .pc(pc), .retire(retire),
        .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
        .core_rst(z_core_rst), .running(z_running), .done(z_done), .timeout(z_timeout),
        .pass(z_pass), .cycle_cnt(z_cycle_cnt), .retire_cnt(z_retire_cnt),
        .halt_pc(z_halt_pc), .result(z_result)
    );

    typedef struct {
        logic [2:0]  ctl;   // start, retire, rd_we
        logic [4:0]  ra;
        logic [31:0] pc;
        logic [31:0] rd;
        logic [3:0]  exp;   // core_rst, running, done, pass
        logic [31:0] rcnt;
        logic [31:0] res;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic s, input logic r, input logic w, input logic [4:0] a,
                       input logic [31:0] p, input logic [31:0] d);
        start = s; retire = r; rd_we = w; rd_addr = a; pc = p; rd_data = d;
    endtask

    task automatic launch_run();
        drv(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        step();
        drv(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        repeat (3) step();
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < NV; i++) begin
            drv(tbl[i].ctl[2], tbl[i].ctl[1], tbl[i].ctl[0], tbl[i].ra, tbl[i].pc, tbl[i].rd);
            step();
            check($sformatf("%s[%0d].core_rst", tag, i), 32'(core_rst), 32'(tbl[i].exp[3]));
            check($sformatf("%s[%0d].running", tag, i), 32'(running), 32'(tbl[i].exp[2]));
            check($sformatf("%s[%0d].done", tag, i), 32'(done), 32'(tbl[i].exp[1]));
            check($sformatf("%s[%0d].pass", tag, i), 32'(pass), 32'(tbl[i].exp[0]));
            check($sformatf("%s[%0d].timeout", tag, i), 32'(timeout), 32'd0);
            check($sformatf("%s[%0d].retire_cnt", tag, i), retire_cnt, tbl[i].rcnt);
            check($sformatf("%s[%0d].result", tag, i), result, tbl[i].res);
        end
        drv(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        check({tag, ".halt_pc"}, halt_pc, 32'h20);
        check({tag, ".cycle_cnt"}, cycle_cnt, 32'd11);
    endtask

    initial begin
        // start is ignored in row 9; row 5 writes x0; row 15 retires after halt.
        tbl[0]  = '{3'b100, 5'd0,  32'h00, 32'h0,    4'b1000, 32'd0,  32'h0};
        tbl[1]  = '{3'b000, 5'd0,  32'h00, 32'h0,    4'b1000, 32'd0,  32'h0};
        tbl[2]  = '{3'b000, 5'd0,  32'h00, 32'h0,    4'b1000, 32'd0,  32'h0};
        tbl[3]  = '{3'b000, 5'd0,  32'h00, 32'h0,    4'b0100, 32'd0,  32'h0};
        tbl[4]  = '{3'b011, 5'd10, 32'h00, 32'h7,    4'b0100, 32'd1,  32'h7};
        tbl[5]  = '{3'b011, 5'd0,  32'h04, 32'hDEAD, 4'b0100, 32'd2,  32'h7};
        tbl[6]  = '{3'b011, 5'd10, 32'h08, 32'h0,    4'b0100, 32'd3,  32'h0};
        tbl[7]  = '{3'b000, 5'd0,  32'h08, 32'h0,    4'b0100, 32'd3,  32'h0};
        tbl[8]  = '{3'b010, 5'd0,  32'h0C, 32'h0,    4'b0100, 32'd4,  32'h0};
        tbl[9]  = '{3'b110, 5'd0,  32'h10, 32'h0,    4'b0100, 32'd5,  32'h0};
        tbl[10] = '{3'b010, 5'd0,  32'h14, 32'h0,    4'b0100, 32'd6,  32'h0};
        tbl[11] = '{3'b010, 5'd0,  32'h18, 32'h0,    4'b0100, 32'd7,  32'h0};
        tbl[12] = '{3'b010, 5'd0,  32'h1C, 32'h0,    4'b0100, 32'd8,  32'h0};
        tbl[13] = '{3'b010, 5'd0,  32'h20, 32'h0,    4'b0100, 32'd9,  32'h0};
        tbl[14] = '{3'b010, 5'd0,  32'h20, 32'h0,    4'b1011, 32'd10, 32'h0};
        tbl[15] = '{3'b011, 5'd10, 32'h20, 32'h3,    4'b1011, 32'd10, 32'h0};

        // Power-on
        rst = 1'b1;
        drv(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("por.core_rst", 32'(core_rst), 32'd1);
        check("por.running", 32'(running), 32'd0);
        check("por.done", 32'(done), 32'd0);
        check("por.timeout", 32'(timeout), 32'd0);
        check("por.pass", 32'(pass), 32'd0);
        check("por.cycle_cnt", cycle_cnt, 32'd0);
        check("por.retire_cnt", retire_cnt, 32'd0);
        check("por.halt_pc", halt_pc, 32'd0);
        check("por.result", result, 32'd0);

        // Normal run, then the x0-result instance after the same program
        run_table("run1");
        check("x0.done", 32'(z_done), 32'd1);
        check("x0.pass", 32'(z_pass), 32'd1);
        check("x0.result", z_result, 32'd0);
        check("x0.halt_pc", z_halt_pc, 32'h20);
        check("x0.retire_cnt", z_retire_cnt, 32'd10);
        check("x0.cycle_cnt", z_cycle_cnt, 32'd11);
        check("x0.core_rst", 32'(z_core_rst), 32'd1);
        check("x0.running", 32'(z_running), 32'd0);
        check("x0.timeout", 32'(z_timeout), 32'd0);

        // Restart from HALTED reproduces the same run
        run_table("run2");

        // Fail result, written in the halting cycle
        launch_run();
        check("fail.running", 32'(running), 32'd1);
        drv(1'b0, 1'b1, 1'b1, 5'd10, 32'h40, 32'h1); step();
        drv(1'b0, 1'b1, 1'b0, 5'd0,  32'h44, 32'h0); step();
        drv(1'b0, 1'b1, 1'b1, 5'd10, 32'h44, 32'h5); step();
        drv(1'b0, 1'b0, 1'b0, 5'd0,  32'h0,  32'h0);
        check("fail.done", 32'(done), 32'd1);
        check("fail.pass", 32'(pass), 32'd0);
        check("fail.result", result, 32'h5);
        check("fail.halt_pc", halt_pc, 32'h44);
        check("fail.retire_cnt", retire_cnt, 32'd3);
        check("fail.cycle_cnt", cycle_cnt, 32'd3);

        // Timeout: PC never repeats
        launch_run();
        for (int i = 0; i < 50; i++) begin
            drv(1'b0, 1'b1, 1'b0, 5'd0, 32'h100 + 32'(4 * i), 32'h0);
            step();
            if (i == 48) begin
                check("tmo.early_timeout", 32'(timeout), 32'd0);
                check("tmo.early_cycle_cnt", cycle_cnt, 32'd49);
            end
        end
        check("tmo.timeout", 32'(timeout), 32'd1);
        check("tmo.cycle_cnt", cycle_cnt, 32'd50);
        check("tmo.core_rst", 32'(core_rst), 32'd1);
        check("tmo.done", 32'(done), 32'd0);
        check("tmo.pass", 32'(pass), 32'd0);
        check("tmo.running", 32'(running), 32'd0);
        drv(1'b0, 1'b1, 1'b0, 5'd0, 32'h500, 32'h0);
        step();
        drv(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        check("tmo.retire_hold", retire_cnt, 32'd50);
        check("tmo.cycle_hold", cycle_cnt, 32'd50);

        // Halt lands on the same cycle as the timeout limit
        drv(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        step();
        check("sim.timeout_cleared", 32'(timeout), 32'd0);
        drv(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        repeat (3) step();
        for (int i = 0; i < 48; i++) begin
            drv(1'b0, 1'b1, 1'b0, 5'd0, 32'h200 + 32'(4 * i), 32'h0);
            step();
        end
        drv(1'b0, 1'b1, 1'b0, 5'd0, 32'h300, 32'h0); step();
        check("sim.not_yet_done", 32'(done), 32'd0);
        step();
        drv(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        check("sim.done", 32'(done), 32'd1);
        check("sim.timeout", 32'(timeout), 32'd0);
        check("sim.cycle_cnt", cycle_cnt, 32'd50);
        check("sim.halt_pc", halt_pc, 32'h300);
        check("sim.retire_cnt", retire_cnt, 32'd50);

        // Asynchronous reset after 10 RUN cycles
        launch_run();
        for (int i = 0; i < 10; i++) begin
            drv(1'b0, 1'b1, (i == 2), 5'd10, 32'h400 + 32'(4 * i), 32'h55);
            step();
        end
        drv(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        check("mid.cycle_cnt_pre", cycle_cnt, 32'd10);
        check("mid.result_pre", result, 32'h55);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid.core_rst", 32'(core_rst), 32'd1);
        check("mid.running", 32'(running), 32'd0);
        check("mid.cycle_cnt", cycle_cnt, 32'd0);
        check("mid.retire_cnt", retire_cnt, 32'd0);
        check("mid.result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("mid.idle_core_rst", 32'(core_rst), 32'd1);
        check("mid.idle_running", 32'(running), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
